// File: rtl/pixel_stream_provider.sv
// Loads one SCANLINE_WIDTH x LINES tile of CHANNELS-byte pixels, then streams whole pixels with x/y and eol/last markers.
// Optional bottom-up line order is compiled in with `define PIXEL_PROVIDER_VFLIP_EN (adds the vflip input).
module pixel_stream_provider #(
    parameter int DATA_W         = 8,
    parameter int CHANNELS       = 3,
    parameter int SCANLINE_WIDTH = 6,
    parameter int LINES          = 3,
    localparam int SIZE = SCANLINE_WIDTH * LINES * CHANNELS,
    localparam int XW   = (SCANLINE_WIDTH > 1) ? $clog2(SCANLINE_WIDTH) : 1,
    localparam int YW   = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
`ifdef PIXEL_PROVIDER_VFLIP_EN
    input  logic                       vflip,
`endif
    input  logic                       i_valid,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       i_ready,
    input  logic                       restart,
    output logic [CHANNELS*DATA_W-1:0] o_data,
    output logic                       o_valid,
    output logic [XW-1:0]              o_x,
    output logic [YW-1:0]              o_y,
    output logic                       o_eol,
    output logic                       o_last,
    output logic                       d_ok,
    output logic [15:0]                led
);

    localparam int NPIX = SCANLINE_WIDTH * LINES;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW   = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        EMIT = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_next;

    logic [CHANNELS*DATA_W-1:0] buffer [NPIX];
    logic [CW-1:0]  count;
    logic [PW-1:0]  ld_pix;
    logic [CHW-1:0] ld_ch;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [YW-1:0]  line;
    logic [PW-1:0]  rd_idx;
    logic           accept, load_done, at_eol, at_last;
`ifdef PIXEL_PROVIDER_VFLIP_EN
    logic           flip;
`endif

    assign i_ready   = (state == LOAD);
    assign accept    = i_valid && (state == LOAD);
    assign load_done = accept && (count == CW'(SIZE - 1));
    assign at_eol    = (x == XW'(SCANLINE_WIDTH - 1));
    assign at_last   = at_eol && (y == YW'(LINES - 1));
    assign led       = {2'(state), 14'(count)};

`ifdef PIXEL_PROVIDER_VFLIP_EN
    assign line = flip ? (YW'(LINES - 1) - y) : y;
`else
    assign line = y;
`endif
    assign rd_idx = PW'(int'(line) * SCANLINE_WIDTH + int'(x));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (load_done) state_next = EMIT;
            EMIT:    if (ena && at_last) state_next = DONE;
            DONE:    if (restart) state_next = EMIT;
            default: state_next = LOAD;
        endcase
    end

    // Tile storage is never reset; it is fully rewritten by every load.
    always_ff @(posedge clk) begin
        if (accept) buffer[ld_pix][ld_ch*DATA_W +: DATA_W] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data <= '0;
            o_valid <= 1'b0;
            o_x <= '0;
            o_y <= '0;
            o_eol <= 1'b0;
            o_last <= 1'b0;
            d_ok <= 1'b0;
            count <= '0;
            ld_pix <= '0;
            ld_ch <= '0;
            x <= '0;
            y <= '0;
`ifdef PIXEL_PROVIDER_VFLIP_EN
            flip <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;
            o_eol <= 1'b0;
            o_last <= 1'b0;
            case (state)
                LOAD: if (accept) begin
                    if (load_done) begin
                        count <= '0;
                        ld_pix <= '0;
                        ld_ch <= '0;
`ifdef PIXEL_PROVIDER_VFLIP_EN
                        flip <= vflip;
`endif
                    end else begin
                        count <= count + 1'b1;
                        if (ld_ch == CHW'(CHANNELS - 1)) begin
                            ld_ch <= '0;
                            ld_pix <= ld_pix + 1'b1;
                        end else begin
                            ld_ch <= ld_ch + 1'b1;
                        end
                    end
                end
                EMIT: if (ena) begin
                    o_data <= buffer[rd_idx];
                    o_x <= x;
                    o_y <= y;
                    o_valid <= 1'b1;
                    o_eol <= at_eol;
                    o_last <= at_last;
                    count <= count + 1'b1;
                    if (at_eol) begin
                        x <= '0;
                        y <= at_last ? '0 : y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                    if (at_last) d_ok <= 1'b1;
                end
                DONE: if (restart) begin
                    x <= '0;
                    y <= '0;
                    count <= '0;
                    d_ok <= 1'b0;
`ifdef PIXEL_PROVIDER_VFLIP_EN
                    flip <= vflip;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_provider.sv
// Randomised bench for pixel_stream_provider: a pixel-order reference model is stepped every cycle and compared with the DUT.
module tb_pixel_stream_provider;

    localparam int W    = 6;
    localparam int L    = 3;
    localparam int C    = 3;
    localparam int DW   = 8;
    localparam int NPIX = W * L;
    localparam int SIZE = NPIX * C;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_ready;
    logic          restart = 1'b0;
    logic [C*DW-1:0] o_data;
    logic          o_valid;
    logic [2:0]    o_x;
    logic [1:0]    o_y;
    logic          o_eol, o_last, d_ok;
    logic [15:0]   led;
    logic          flip_in;
`ifdef PIXEL_PROVIDER_VFLIP_EN
    logic          vflip = 1'b0;
    assign flip_in = vflip;
`else
    assign flip_in = 1'b0;
`endif

    pixel_stream_provider #(
        .DATA_W(DW), .CHANNELS(C), .SCANLINE_WIDTH(W), .LINES(L)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
`ifdef PIXEL_PROVIDER_VFLIP_EN
        .vflip(vflip),
`endif
        .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready), .restart(restart),
        .o_data(o_data), .o_valid(o_valid), .o_x(o_x), .o_y(o_y),
        .o_eol(o_eol), .o_last(o_last), .d_ok(d_ok), .led(led)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: phase 0 = loading, 1 = emitting, 2 = finished.
    logic [DW-1:0] mem [SIZE];
    int  m_phase = 0, m_nb = 0, m_e = 0, m_cnt = 0, m_x = 0, m_y = 0;
    bit  m_dok = 0, m_valid = 0, m_eol = 0, m_last = 0, m_flip = 0;
    logic [C*DW-1:0] m_data = '0;

    task automatic model_step();
        int line;
        if (rst) begin
            m_phase = 0; m_nb = 0; m_e = 0; m_cnt = 0; m_x = 0; m_y = 0;
            m_dok = 0; m_valid = 0; m_eol = 0; m_last = 0; m_flip = 0; m_data = '0;
        end else begin
            m_valid = 0; m_eol = 0; m_last = 0;
            case (m_phase)
                0: if (i_valid) begin
                    mem[m_nb] = i_data;
                    m_nb++;
                    m_cnt = m_nb;
                    if (m_nb == SIZE) begin
                        m_phase = 1; m_e = 0; m_cnt = 0; m_flip = flip_in;
                    end
                end
                1: if (ena) begin
                    m_y = m_e / W;
                    m_x = m_e % W;
                    line = m_flip ? (L - 1 - m_y) : m_y;
                    for (int c = 0; c < C; c++)
                        m_data[c*DW +: DW] = mem[(line * W + m_x) * C + c];
                    m_valid = 1;
                    m_eol = (m_x == W - 1);
                    m_last = (m_e == NPIX - 1);
                    m_e++;
                    m_cnt = m_e;
                    if (m_e == NPIX) begin
                        m_phase = 2; m_dok = 1;
                    end
                end
                default: if (restart) begin
                    m_phase = 1; m_e = 0; m_cnt = 0; m_dok = 0; m_flip = flip_in;
                end
            endcase
        end
    endtask

    logic [C*DW-1:0] seen[$];
    logic [4:0]      seen_pos[$];

    // Inputs change at negedge+1, so at the negedge they still hold what the last posedge sampled.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            chk("i_ready", i_ready, (m_phase == 0));
            chk("o_valid", o_valid, m_valid);
            chk("o_eol", o_eol, m_eol);
            chk("o_last", o_last, m_last);
            chk("d_ok", d_ok, m_dok);
            chk("o_data", o_data, m_data);
            chk("o_x", o_x, 64'(m_x));
            chk("o_y", o_y, 64'(m_y));
            chk("led", led, 64'((m_phase << 14) | (m_cnt & 32'h3fff)));
            if (o_valid) begin
                seen.push_back(o_data);
                seen_pos.push_back({o_y, o_x});
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!d_ok && n < budget) begin
            cyc();
            n++;
        end
        chk(nm, d_ok, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic load_seq(input int base, input bit gaps);
        for (int k = 0; k < SIZE; k++) begin
            i_valid = 1'b1;
            i_data = 8'(base + k);
            cyc();
            if (gaps) begin
                i_valid = 1'b0;
                i_data = 8'($urandom);
                ena = 1'($urandom_range(0, 1));
                cyc();
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            ena = 1'($urandom_range(0, 1));
            i_valid = 1'($urandom_range(0, 1));
            i_data = 8'($urandom);
            restart = ($urandom_range(0, 7) == 0);
`ifdef PIXEL_PROVIDER_VFLIP_EN
            vflip = 1'($urandom_range(0, 1));
`endif
            cyc();
        end
        ena = 1'b0; i_valid = 1'b0; restart = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_ready", i_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_led", led, 0);
        rst = 1'b0;

        // Straight load of 1..54 and continuous emission.
        seen.delete(); seen_pos.delete();
        ena = 1'b1;
        load_seq(1, 0);
        chk("s1_ready_low", i_ready, 0);
        wait_done(100, "s1_done");
        chk("s1_count", seen.size(), 18);
        if (seen.size() == 18) begin
            chk("s1_first", seen[0], 24'h030201);
            chk("s1_pix6", seen[6], 24'h151413);
            chk("s1_pos6", seen_pos[6], 5'b01000);
            chk("s1_last", seen[17], 24'h363534);
        end
        chk("s1_led", led, 16'h8012);

        // Replay with ena toggling every cycle.
        seen.delete(); seen_pos.delete();
        ena = 1'b0;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk("s2_dok_clear", d_ok, 0);
        for (int i = 0; i < 36; i++) begin
            ena = (i % 2 == 0);
            cyc();
        end
        ena = 1'b0;
        wait_done(10, "s2_done");
        chk("s2_count", seen.size(), 18);
        if (seen.size() == 18) chk("s2_last", seen[17], 24'h363534);

        // Restart mid-emission is ignored; reset after 9 pixels, reload with gaps.
        seen.delete(); seen_pos.delete();
        restart = 1'b1; ena = 1'b1;
        cyc();
        restart = 1'b0;
        repeat (3) cyc();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        for (int n = 0; n < 50 && seen.size() < 9; n++) cyc();
        chk("s3_nine", seen.size(), 9);
        rst = 1'b1;
        #1;
        chk("s3_rst_valid", o_valid, 0);
        chk("s3_rst_data", o_data, 0);
        chk("s3_rst_xy", {o_y, o_x}, 0);
        chk("s3_rst_dok", d_ok, 0);
        chk("s3_rst_ready", i_ready, 1);
        chk("s3_rst_led", led, 0);
        cyc();
        rst = 1'b0;
        seen.delete(); seen_pos.delete();
        load_seq(101, 1);
        ena = 1'b1;
        wait_done(100, "s3_done");
        if (seen.size() > 0) chk("s3_first", seen[0], 24'h676665);

`ifdef PIXEL_PROVIDER_VFLIP_EN
        // Bottom-up emission of the 1..54 tile.
        do_reset();
        seen.delete(); seen_pos.delete();
        vflip = 1'b1; ena = 1'b1;
        load_seq(1, 0);
        vflip = 1'b0;
        wait_done(100, "vf_done");
        if (seen.size() == 18) begin
            chk("vf_first", seen[0], 24'h272625);
            chk("vf_first_pos", seen_pos[0], 5'b00000);
            chk("vf_last", seen[17], 24'h121110);
        end
`endif

        // Fully random traffic over several reloads.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            run_random(400);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
